// File: rtl/pnr_photon_histogram.sv
// Per-trigger photon-number histogram: bins 0..7, overflow, error and event counters with readout.
// Optional PNR_HIST_SATURATE_EN makes every counter saturate instead of wrapping.
module pnr_photon_histogram #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             ADC_CLK,
  input  logic             rstn_i,
  input  logic [7:0]       seg_i,
  input  logic             seg_valid_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [CNT_W-1:0] cfg_num_events,
  input  logic [3:0]       rd_addr_i,
  output logic [CNT_W-1:0] rd_data_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [1:0] {StIdle, StAcq, StDone} state_e;

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bin_q [8];
  logic [CNT_W-1:0] bin_d [8];
  logic [CNT_W-1:0] ovf_q, ovf_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] evt_q, evt_d;
  logic [CNT_W-1:0] cfg_q, cfg_d;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] x);
`ifdef PNR_HIST_SATURATE_EN
    return (x == {CNT_W{1'b1}}) ? x : x + CntOne;
`else
    return x + CntOne;
`endif
  endfunction

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    evt_d   = evt_q;
    cfg_d   = cfg_q;

    // start overrides everything, including a coincident valid and stop
    if (start_i) begin
      for (int k = 0; k < 8; k++) bin_d[k] = '0;
      ovf_d   = '0;
      err_d   = '0;
      evt_d   = '0;
      cfg_d   = cfg_num_events;
      state_d = StAcq;
    end else begin
      case (state_q)
        StAcq: begin
          if (seg_valid_i) begin
            if (seg_i == 8'h00) begin
              ovf_d = cnt_inc(ovf_q);
            end else if ($onehot(seg_i)) begin
              for (int k = 0; k < 8; k++) begin
                if (seg_i[k]) bin_d[k] = cnt_inc(bin_q[k]);
              end
            end else begin
              err_d = cnt_inc(err_q);
            end
            evt_d = cnt_inc(evt_q);
            if ((cfg_q != '0) && (evt_d == cfg_q)) state_d = StDone;
          end
          if (stop_i) state_d = StIdle;
        end
        StDone: begin
          if (stop_i) state_d = StIdle;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_data_d = '0;
    if (!rd_addr_i[3]) begin
      rd_data_d = bin_q[rd_addr_i[2:0]];
    end else begin
      case (rd_addr_i[2:0])
        3'd0:    rd_data_d = ovf_q;
        3'd1:    rd_data_d = err_q;
        3'd2:    rd_data_d = evt_q;
        default: rd_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge ADC_CLK) begin
    if (!rstn_i) begin
      state_q   <= StIdle;
      for (int k = 0; k < 8; k++) bin_q[k] <= '0;
      ovf_q     <= '0;
      err_q     <= '0;
      evt_q     <= '0;
      cfg_q     <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      for (int k = 0; k < 8; k++) bin_q[k] <= bin_d[k];
      ovf_q     <= ovf_d;
      err_q     <= err_d;
      evt_q     <= evt_d;
      cfg_q     <= cfg_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;
  assign busy_o    = (state_q == StAcq);
  assign done_o    = (state_q == StDone);

endmodule
